// File: rtl/ldpc_pkg.sv
// Shared constants and types for the cyclic (15-bit) LDPC bit-flipping decoder.
// The offset tables describe one row and one column of the circulant H matrix.
package ldpc_pkg;

    localparam int N    = 15;
    localparam int NTAP = 4;

    // Check i covers bits i+CHECK_TAPS[t]; bit j sits in checks j+BIT_CHECKS[t] (mod N).
    localparam int CHECK_TAPS [NTAP] = '{0, 8, 9, 11};
    localparam int BIT_CHECKS [NTAP] = '{0, 4, 6, 7};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FLIP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int wrap_idx(input int i);
        return i % N;
    endfunction

endpackage

// File: rtl/ldpc_bf_ctrl_syndrome.sv
// Combinational syndrome detector: one parity per check row of the circulant H,
// plus an error flag that is set when any check is unsatisfied.
module ldpc_bf_ctrl_syndrome
    import ldpc_pkg::*;
(
    input  logic [N-1:0] cw,
    output logic [N-1:0] syndrome,
    output logic         error
);

    for (genvar i = 0; i < N; i++) begin : g_check
        assign syndrome[i] = cw[wrap_idx(i + CHECK_TAPS[0])] ^
                             cw[wrap_idx(i + CHECK_TAPS[1])] ^
                             cw[wrap_idx(i + CHECK_TAPS[2])] ^
                             cw[wrap_idx(i + CHECK_TAPS[3])];
    end

    assign error = |syndrome;

endmodule

// File: rtl/ldpc_bf_ctrl.sv
// Hard-decision bit-flipping decoder controller: accepts one word, iterates
// check/flip until the syndrome clears or the iteration budget runs out.
module ldpc_bf_ctrl
    import ldpc_pkg::*;
#(
    parameter int MAX_ITER    = 8,
    parameter int FLIP_THRESH = 3,
    parameter int IW          = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_cw,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_cw,
    output logic          out_fail,
    output logic [IW-1:0] out_iters,
    output state_t        fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid and its payload hold steady until that edge is reached.

    localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);
    localparam logic [2:0]    THRESH     = 3'(FLIP_THRESH);

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    cw;
    logic [N-1:0]    fr;
    logic [IW-1:0]   iter;
    logic            fail;
    logic [N-1:0]    syndrome;
    logic            error;
    logic [N-1:0]    flip_mask;

    logic            load;
    logic            do_flip;
    logic            mask_we;
    logic            fail_we;
    logic            fail_val;

    ldpc_bf_ctrl_syndrome u_syndrome (
        .cw       (cw),
        .syndrome (syndrome),
        .error    (error)
    );

    // Unsatisfied-check count per bit, compared against the flip threshold.
    for (genvar j = 0; j < N; j++) begin : g_bit
        logic [2:0] unsat;
        assign unsat = {2'b00, syndrome[wrap_idx(j + BIT_CHECKS[0])]} +
                       {2'b00, syndrome[wrap_idx(j + BIT_CHECKS[1])]} +
                       {2'b00, syndrome[wrap_idx(j + BIT_CHECKS[2])]} +
                       {2'b00, syndrome[wrap_idx(j + BIT_CHECKS[3])]};
        assign flip_mask[j] = (unsat >= THRESH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        do_flip    = 1'b0;
        mask_we    = 1'b0;
        fail_we    = 1'b0;
        fail_val   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (!error) begin
                    fail_we    = 1'b1;
                    fail_val   = 1'b0;
                    state_next = DONE;
                end else if (iter == ITER_LIMIT || flip_mask == '0) begin
                    // An all-zero mask would never make progress, so it fails now.
                    fail_we    = 1'b1;
                    fail_val   = 1'b1;
                    state_next = DONE;
                end else begin
                    mask_we    = 1'b1;
                    state_next = FLIP;
                end
            end
            FLIP: begin
                do_flip    = 1'b1;
                state_next = CHECK;
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw   <= '0;
            fr   <= '0;
            iter <= '0;
            fail <= 1'b0;
        end else begin
            if (load) begin
                cw   <= in_cw;
                iter <= '0;
            end else if (do_flip) begin
                cw   <= cw ^ fr;
                iter <= iter + IW'(1);
            end
            if (mask_we) begin
                fr <= flip_mask;
            end
            if (fail_we) begin
                fail <= fail_val;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_cw    = cw;
    assign out_fail  = fail;
    assign out_iters = iter;
    assign fsm_state = state;

endmodule
